// File: rtl/ntt_poly_mult_driver.sv
// ntt_poly_mult_driver
// Host-side sequencer for the NTT polynomial multiplier core. It takes one
// stream of 2*N coefficients (A then B), loads them into the core, runs one
// multiplication job, and streams the N result coefficients back out under
// downstream backpressure.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   in_valid/in_data/in_ready      coefficient input stream (A[0..N-1], B[0..N-1])
//   out_valid/out_data/out_last    result stream, index order, last = index N-1
//   out_ready                      downstream accept
//   job_busy                       high in every state except IDLE
//   job_done                       one-cycle pulse after the final result handshake
//   load_coeff/load_sel/load_addr/load_data   core load port (sel 0 = A, 1 = B)
//   start                          core start level
//   core_done                      core done level
//   read_addr/read_data            core result port, READ_LATENCY cycles
//
// state    | meaning
// ---------+-------------------------------------------------
// IDLE     | waiting for the first input word
// LOAD_A   | accepting N words of A
// LOAD_B   | accepting N words of B
// START    | start raised, one cycle
// WAIT     | start held, waiting for core_done
// READ     | issuing result reads, draining the result FIFO
// FINISH   | job_done pulse, back to IDLE next cycle
module ntt_poly_mult_driver #(
  parameter int N            = 256,
  parameter int WIDTH        = 32,
  parameter int ADDR_WIDTH   = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  job_busy,
  output logic                  job_done,
  output logic                  load_coeff,
  output logic                  load_sel,
  output logic [ADDR_WIDTH-1:0] load_addr,
  output logic [WIDTH-1:0]      load_data,
  output logic                  start,
  input  logic                  core_done,
  output logic [ADDR_WIDTH-1:0] read_addr,
  input  logic [WIDTH-1:0]      read_data
);

  localparam int IDX_W = $clog2(N + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_START,
    S_WAIT,
    S_READ,
    S_FINISH
  } state_t;

  state_t                  state;
  logic [IDX_W-1:0]        load_idx;
  logic [IDX_W-1:0]        issue_idx;
  logic [IDX_W-1:0]        out_idx;
  logic [2:0]              fifo_count;
  logic [2:0]              inflight;
  logic [1:0]              wr_ptr;
  logic [1:0]              rd_ptr;
  logic [WIDTH-1:0]        fifo_mem [4];
  logic [READ_LATENCY-1:0] issue_pipe;

  logic in_hs;
  logic issue;
  logic push;
  logic pop;

  // in_ready drops once the phase count reaches N, so the transition cycle
  // never accepts a word.
  assign in_ready = ((state == S_LOAD_A) || (state == S_LOAD_B)) &&
                    (load_idx < IDX_W'(N));
  assign in_hs    = in_valid && in_ready;
  assign job_busy = (state != S_IDLE);

  // Reads are only issued when the FIFO has room for everything in flight,
  // so a captured word can never overflow the FIFO.
  assign issue     = (state == S_READ) && (issue_idx < IDX_W'(N)) &&
                     ((fifo_count + inflight) < 3'd4);
  assign read_addr = issue ? issue_idx[ADDR_WIDTH-1:0] : '0;
  assign push      = issue_pipe[READ_LATENCY-1];

  assign out_valid = (fifo_count != 3'd0);
  assign out_data  = out_valid ? fifo_mem[rd_ptr] : '0;
  assign out_last  = out_valid && (out_idx == IDX_W'(N - 1));
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      load_idx   <= '0;
      load_coeff <= 1'b0;
      load_sel   <= 1'b0;
      load_addr  <= '0;
      load_data  <= '0;
      start      <= 1'b0;
      job_done   <= 1'b0;
    end else begin
      load_coeff <= 1'b0;
      job_done   <= 1'b0;
      if (in_hs) begin
        load_coeff <= 1'b1;
        load_sel   <= (state == S_LOAD_B);
        load_addr  <= load_idx[ADDR_WIDTH-1:0];
        load_data  <= in_data;
        load_idx   <= load_idx + 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            state    <= S_LOAD_A;
            load_idx <= '0;
          end
        end
        S_LOAD_A: begin
          if (load_idx == IDX_W'(N)) begin
            state    <= S_LOAD_B;
            load_idx <= '0;
          end
        end
        S_LOAD_B: begin
          if (load_idx == IDX_W'(N)) begin
            state <= S_START;
            start <= 1'b1;
          end
        end
        S_START: state <= S_WAIT;
        S_WAIT: begin
          if (core_done) begin
            state <= S_READ;
            start <= 1'b0;
          end
        end
        S_READ: begin
          if (pop && (out_idx == IDX_W'(N - 1))) begin
            state    <= S_FINISH;
            job_done <= 1'b1;
          end
        end
        S_FINISH: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_idx  <= '0;
      out_idx    <= '0;
      fifo_count <= '0;
      inflight   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      issue_pipe <= '0;
    end else begin
      issue_pipe[0] <= issue;
      for (int i = 1; i < READ_LATENCY; i++) begin
        issue_pipe[i] <= issue_pipe[i-1];
      end
      inflight   <= inflight + 3'(issue) - 3'(push);
      fifo_count <= fifo_count + 3'(push) - 3'(pop);
      if (push) begin
        fifo_mem[wr_ptr] <= read_data;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        out_idx <= out_idx + 1'b1;
      end
      if (state != S_READ) begin
        issue_idx <= '0;
        out_idx   <= '0;
      end else if (issue) begin
        issue_idx <= issue_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ntt_poly_mult_driver.sv
// Bench for ntt_poly_mult_driver: a behavioural multiplier core (negacyclic
// product mod Q, or an addr+100 pattern source) with a two-cycle read port,
// directed jobs with random data and random downstream backpressure.
module tb_ntt_poly_mult_driver;
  localparam int     N   = 256;
  localparam int     W   = 32;
  localparam int     AW  = 8;
  localparam int     RL  = 2;
  localparam longint Q   = 8380417;

  typedef logic [W-1:0] poly_t [N];

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_ready, out_valid, out_last, job_busy, job_done;
  logic [W-1:0]  out_data, load_data, read_data;
  logic          out_ready = 1'b1;
  logic          load_coeff, load_sel, start, core_done;
  logic [AW-1:0] load_addr, read_addr;

  always #5 clk = ~clk;

  ntt_poly_mult_driver #(.N(N), .WIDTH(W), .ADDR_WIDTH(AW), .READ_LATENCY(RL)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .job_busy(job_busy), .job_done(job_done), .load_coeff(load_coeff), .load_sel(load_sel),
    .load_addr(load_addr), .load_data(load_data), .start(start), .core_done(core_done),
    .read_addr(read_addr), .read_data(read_data)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Negacyclic product mod Q: c = a*b mod (x^N + 1).
  function automatic poly_t mulpoly(input poly_t a, input poly_t b);
    poly_t  c;
    longint acc [N];
    longint p;
    for (int k = 0; k < N; k++) acc[k] = 0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        p = (longint'(a[i]) * longint'(b[j])) % Q;
        if (i + j < N) acc[i+j] = (acc[i+j] + p) % Q;
        else           acc[i+j-N] = (acc[i+j-N] + Q - p) % Q;
      end
    end
    for (int k = 0; k < N; k++) c[k] = W'(acc[k]);
    return c;
  endfunction

  // Core model
  poly_t        core_a, core_b, core_c;
  int           core_mode = 0;
  int           core_cnt = 0;
  logic [W-1:0] rd_pipe [RL];
  initial core_done = 1'b0;

  always @(posedge clk) begin
    if (load_coeff) begin
      if (load_sel) core_b[load_addr] = load_data;
      else          core_a[load_addr] = load_data;
    end
    if (rst || !start) begin
      core_done <= 1'b0;
      core_cnt = 0;
    end else if (!core_done) begin
      if (core_cnt == 20) begin
        core_c = mulpoly(core_a, core_b);
        core_done <= 1'b1;
      end
      core_cnt++;
    end
    rd_pipe[0] <= (core_mode == 1) ? (32'(read_addr) + 32'd100) : core_c[read_addr];
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign read_data = rd_pipe[RL-1];

  // Monitors
  int            cyc = 0;
  int            last_load_cyc = 0;
  int            start_rise_cyc = -1;
  logic          start_q = 1'b0;
  int            jd_cnt = 0;
  bit            bp_on = 1'b0;
  logic [W-1:0]  out_q [$];
  logic          last_q [$];
  logic          ld_sel_q [$];
  logic [AW-1:0] ld_addr_q [$];
  logic [W-1:0]  ld_data_q [$];
  logic          stall_prev = 1'b0;
  logic [W-1:0]  stall_data;
  logic          stall_last;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    out_ready = bp_on ? ($urandom_range(99) >= 30) : 1'b1;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (load_coeff) begin
        ld_sel_q.push_back(load_sel);
        ld_addr_q.push_back(load_addr);
        ld_data_q.push_back(load_data);
        last_load_cyc = cyc;
      end
      if (start && !start_q) start_rise_cyc = cyc;
      if (job_done) jd_cnt++;
      if (out_valid && out_ready) begin
        out_q.push_back(out_data);
        last_q.push_back(out_last);
      end
      if (stall_prev) chk("stall_stable", {out_valid, out_last, out_data}, {1'b1, stall_last, stall_data});
    end
    start_q    = start;
    stall_prev = !rst && out_valid && !out_ready;
    stall_data = out_data;
    stall_last = out_last;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_all_zero(input string tag);
    chk(tag, {in_ready, out_valid, out_data, out_last, job_busy, job_done, load_coeff,
              load_sel, load_addr, load_data, start, read_addr}, '0);
  endtask

  task automatic send_words(input poly_t a, input poly_t b, input bit gaps);
    int k = 0;
    int t = 0;
    bit hs;
    while (k < 2*N && t < 20*N) begin
      in_valid = gaps ? (t[0] == 1'b0) : 1'b1;
      in_data  = (k < N) ? a[k] : b[k-N];
      @(negedge clk);
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      if (hs) k++;
      t++;
    end
    in_valid = 1'b0;
    in_data  = '0;
    chk("words_accepted", k, 2*N);
  endtask

  task automatic run_job(input poly_t a, input poly_t b, input bit gaps, input bit bp,
                         input int mode, input poly_t exp, output poly_t got);
    int jd0;
    int t;
    out_q.delete(); last_q.delete();
    ld_sel_q.delete(); ld_addr_q.delete(); ld_data_q.delete();
    start_rise_cyc = -1;
    core_mode = mode;
    jd0 = jd_cnt;
    send_words(a, b, gaps);
    bp_on = bp;
    t = 0;
    while (jd_cnt == jd0 && t < 5000) begin
      @(posedge clk); #1;
      t++;
    end
    bp_on = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("job_done_pulses", jd_cnt - jd0, 1);
    chk("idle_after_job", {job_busy, out_valid, start}, 3'b000);
    chk("start_after_last_load", start_rise_cyc - last_load_cyc, 1);
    chk("load_count", ld_sel_q.size(), 2*N);
    for (int i = 0; i < ld_sel_q.size() && i < 2*N; i++) begin
      chk("load_sel", ld_sel_q[i], (i >= N));
      chk("load_addr", ld_addr_q[i], i % N);
      chk("load_data", ld_data_q[i], (i < N) ? a[i] : b[i-N]);
    end
    chk("out_count", out_q.size(), N);
    for (int i = 0; i < N; i++) begin
      got[i] = (i < out_q.size()) ? out_q[i] : 'x;
      if (i < out_q.size()) begin
        chk("out_data", out_q[i], exp[i]);
        chk("out_last", last_q[i], (i == N-1));
      end
    end
  endtask

  poly_t a, b, exp, got, got_ref;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_all_zero("reset_outputs");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // A = 1, B = 5..260: product equals B
    for (int i = 0; i < N; i++) begin
      a[i] = (i == 0) ? 32'd1 : 32'd0;
      b[i] = 32'(i + 5);
      exp[i] = 32'(i + 5);
    end
    run_job(a, b, 1'b0, 1'b0, 0, exp, got);

    // x * x = x^2
    for (int i = 0; i < N; i++) begin
      a[i] = (i == 1) ? 32'd1 : 32'd0;
      b[i] = a[i];
      exp[i] = (i == 2) ? 32'd1 : 32'd0;
    end
    run_job(a, b, 1'b0, 1'b0, 0, exp, got);

    // random data, without then with backpressure; streams must be identical
    for (int i = 0; i < N; i++) begin
      a[i] = $urandom_range(int'(Q) - 1);
      b[i] = $urandom_range(int'(Q) - 1);
    end
    exp = mulpoly(a, b);
    run_job(a, b, 1'b0, 1'b0, 0, exp, got_ref);
    run_job(a, b, 1'b0, 1'b1, 0, exp, got);
    for (int i = 0; i < N; i++) chk("bp_vs_nobp", got[i], got_ref[i]);

    // addr+100 core with gapped input
    for (int i = 0; i < N; i++) begin
      a[i] = $urandom();
      b[i] = $urandom();
      exp[i] = 32'(i + 100);
    end
    run_job(a, b, 1'b1, 1'b1, 1, exp, got);

    // reset while waiting on the core
    core_mode = 0;
    send_words(a, b, 1'b0);
    for (int t = 0; t < 100 && !start; t++) begin
      @(posedge clk); #1;
    end
    chk("reached_wait", start, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    begin
      int jd0;
      jd0 = jd_cnt;
      rst = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check_all_zero("reset_in_wait");
      repeat (40) @(posedge clk);
      #1;
      chk("no_done_after_reset", {jd_cnt - jd0, 31'd0, job_busy}, 64'd0);
    end

    // fresh job after reset, gaps and backpressure
    for (int i = 0; i < N; i++) begin
      a[i] = $urandom_range(int'(Q) - 1);
      b[i] = $urandom_range(int'(Q) - 1);
    end
    exp = mulpoly(a, b);
    run_job(a, b, 1'b1, 1'b1, 0, exp, got);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ntt_poly_mult_driver.md
Name: ntt_poly_mult_driver

Overview:
- Host-side sequencer that drives the load/start/done/read interface of the NTT polynomial multiplier core.
- Accepts one input stream of 2*N coefficients: N words of A, then N words of B.
- Writes them into the core, runs one multiplication job, then reads the N result coefficients back and emits them on a backpressured output stream.
- Sits between a bus/DMA stream adapter and the multiplier core.

Parameters:
- N, 256, polynomial length (power of two).
- WIDTH, 32, coefficient width.
- ADDR_WIDTH, 8, core address width, equal to log2(N).
- READ_LATENCY, 1, cycles from core read_addr to valid read_data; legal values 1..2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  input coefficient valid.
- in_data  in  WIDTH  input coefficient.
- in_ready  out  1  driver accepts in_data.
- out_valid  out  1  result coefficient valid.
- out_data  out  WIDTH  result coefficient, index order 0..N-1.
- out_last  out  1  marks result index N-1.
- out_ready  in  1  downstream accepts out_data.
- job_busy  out  1  job in progress.
- job_done  out  1  one-cycle pulse after the final result handshake.
- load_coeff  out  1  core load strobe.
- load_sel  out  1  0 = A, 1 = B.
- load_addr  out  ADDR_WIDTH  core load address.
- load_data  out  WIDTH  core load data.
- start  out  1  core start, level.
- core_done  in  1  core done level.
- read_addr  out  ADDR_WIDTH  core result address.
- read_data  in  WIDTH  core result data.

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset: all outputs 0, state IDLE, all counters 0, result FIFO empty. Reset mid-job abandons the job with no job_done pulse. The core shares the system reset.
- States:
  - IDLE -> LOAD_A on in_valid.
  - LOAD_A -> LOAD_B after N input handshakes.
  - LOAD_B -> START after N handshakes.
  - START -> WAIT after 1 cycle.
  - WAIT -> READ on core_done.
  - READ -> FINISH when N results have handshaked on out.
  - FINISH -> IDLE after 1 cycle, which is the job_done cycle.
- in_ready = 1 only in LOAD_A and LOAD_B. It is 0 on the cycle the state moves to the next phase, so at most N words are accepted per phase.
- Load path: registered. A handshake in cycle t gives load_coeff=1 in t+1 with load_addr = phase index, load_sel = phase, and load_data = the accepted word. Otherwise load_coeff=0 and load_addr/data/sel hold their values.
- Load index uses $clog2(N+1) bits and clears on phase entry.
- start:
  - Goes high on the cycle START is entered, which is the cycle after the final B load_coeff pulse.
  - Stays high through WAIT.
  - Drops on the cycle after core_done is first seen high, i.e. in the first READ cycle.
- core_done outside WAIT is ignored.
- job_busy = 1 in every state except IDLE.
- READ path:
  - 4-entry result FIFO with an in-flight counter.
  - A read issues (read_addr = issue index, index++) in a cycle when issue index < N and fifo_count + inflight < 4.
  - Data is captured into the FIFO exactly READ_LATENCY cycles after issue.
  - read_addr = 0 when not issuing.
- Output stream:
  - out_valid = FIFO non-empty; out_data = FIFO head.
  - out_last = 1 when the head is index N-1.
  - Pop on out_valid && out_ready.
  - With out_ready held high, throughput is 1 word/cycle after the initial latency.
- Output stream rules:
  - out_data/out_last stay stable while out_valid && !out_ready.
  - No data loss under arbitrary backpressure.
  - Simultaneous push and pop in one cycle leaves fifo_count unchanged.
- FINISH: job_done = 1 for exactly one cycle. in_valid is not accepted until IDLE. The next job may start in the cycle after FINISH.
- in_valid gaps: loading pauses and the load index holds.

Test Plan:
- A = [1,0,...,0], B = [5,6,...,260] with out_ready=1 and a real core (Q=8380417) -> out_data = 5..260 in order; out_last only on word 255; one job_done pulse.
- A = B = [0,1,0,...] (x) -> result x^2: word 2 = 1, all other words 0.
- Random out_ready at 30% during READ -> outputs are bit-identical to the no-backpressure run; FIFO never exceeds 4 entries; payload stays stable while stalled.
- READ_LATENCY=2 with a core model returning addr+100 -> out_data sequence 100..355 with no drops or duplicates.
- in_valid toggled every other cycle -> exactly 256 load_coeff pulses with load_sel=0 on addresses 0..255, then 256 with load_sel=1; start rises exactly one cycle after the last pulse.
- Assert rst during WAIT -> next cycle all outputs 0 and state IDLE; no job_done; a fresh job then completes correctly.
